// File: rtl/flu_binder_arb_pkg.sv
// Shared types and elaboration helpers for the FLU packet-level binder arbiter.
package flu_binder_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int log2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Byte offset at which a packet starting in block sop_pos begins.
  function automatic int cont_start_byte(input int sop_pos, input int data_width,
                                         input int sop_pos_width);
    return (sop_pos * (data_width >> sop_pos_width)) / 8;
  endfunction

endpackage

// File: rtl/flu_binder_rr_sel.sv
// Combinational cyclic find-first: lowest-distance requester at or after ptr.
module flu_binder_rr_sel #(
  parameter int PORTS = 4,
  parameter int IDX_W = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             grant_vld
);

  logic [2*PORTS-1:0] req_dbl;
  logic [2*PORTS-1:0] req_rot;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr;

  always_comb begin
    int sum;
    grant     = '0;
    grant_vld = 1'b0;
    sum       = 0;
    for (int k = 0; k < PORTS; k++) begin
      if (!grant_vld && req_rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= PORTS) sum = sum - PORTS;
        grant     = IDX_W'(sum);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flu_binder_arbiter.sv
// Packet-level round-robin merge of PORTS FLU streams into one registered FLU output.
// A port is granted only on SOP and holds the output until its packet ends.
module flu_binder_arbiter
  import flu_binder_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 256,
  parameter int SOP_POS_WIDTH = 2,
  parameter int PORTS         = 4,
  parameter int EOP_POS_WIDTH = log2(DATA_WIDTH / 8)
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [PORTS*DATA_WIDTH-1:0]      RX_DATA,
  input  logic [PORTS*SOP_POS_WIDTH-1:0]   RX_SOP_POS,
  input  logic [PORTS*EOP_POS_WIDTH-1:0]   RX_EOP_POS,
  input  logic [PORTS-1:0]                 RX_SOP,
  input  logic [PORTS-1:0]                 RX_EOP,
  input  logic [PORTS-1:0]                 RX_SRC_RDY,
  output logic [PORTS-1:0]                 RX_DST_RDY,
  output logic [DATA_WIDTH-1:0]            TX_DATA,
  output logic [SOP_POS_WIDTH-1:0]         TX_SOP_POS,
  output logic [EOP_POS_WIDTH-1:0]         TX_EOP_POS,
  output logic                             TX_SOP,
  output logic                             TX_EOP,
  output logic                             TX_SRC_RDY,
  input  logic                             TX_DST_RDY
);

  localparam int PTR_W = log2(PORTS);

  arb_state_e state;
  logic [PTR_W-1:0] lock_port;
  logic [PTR_W-1:0] rr_ptr;
  logic             out_vld;

  logic [PORTS-1:0] sop_req;
  logic [PTR_W-1:0] grant;
  logic             grant_vld;
  logic [PTR_W-1:0] sel_port;
  logic [PTR_W-1:0] next_ptr;
  logic             can_accept;
  logic             grant_ok;
  logic [PORTS-1:0] dst_rdy;
  logic             accept;

  logic [DATA_WIDTH-1:0]    sel_data;
  logic [SOP_POS_WIDTH-1:0] sel_sop_pos;
  logic [EOP_POS_WIDTH-1:0] sel_eop_pos;
  logic                     sel_sop;
  logic                     sel_eop;
  logic                     sel_src_rdy;
  logic                     cont;
  logic                     release_pkt;

  assign can_accept = !out_vld || TX_DST_RDY;
  assign sop_req    = RX_SRC_RDY & RX_SOP;

  flu_binder_rr_sel #(
    .PORTS (PORTS),
    .IDX_W (PTR_W)
  ) u_rr_sel (
    .req       (sop_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  assign sel_port = (state == LOCKED) ? lock_port : grant;
  assign next_ptr = (grant == PTR_W'(PORTS - 1)) ? '0 : grant + PTR_W'(1);

  // The IDLE grant is combinational on RX_SRC_RDY/RX_SOP so a new packet can follow an EOP without a bubble.
  assign grant_ok = !RESET && can_accept && ((state == LOCKED) || grant_vld);

  always_comb begin
    dst_rdy = '0;
    for (int i = 0; i < PORTS; i++) begin
      dst_rdy[i] = grant_ok && (PTR_W'(i) == sel_port);
    end
  end

  assign RX_DST_RDY = dst_rdy;

  always_comb begin
    sel_data    = '0;
    sel_sop_pos = '0;
    sel_eop_pos = '0;
    sel_sop     = 1'b0;
    sel_eop     = 1'b0;
    sel_src_rdy = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (PTR_W'(i) == sel_port) begin
        sel_data    = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_sop_pos = RX_SOP_POS[i*SOP_POS_WIDTH +: SOP_POS_WIDTH];
        sel_eop_pos = RX_EOP_POS[i*EOP_POS_WIDTH +: EOP_POS_WIDTH];
        sel_sop     = RX_SOP[i];
        sel_eop     = RX_EOP[i];
        sel_src_rdy = RX_SRC_RDY[i];
      end
    end
  end

  assign accept = sel_src_rdy && grant_ok;

  // A packet that starts after the EOP byte in the same word keeps the port locked.
  assign cont = sel_sop &&
                (cont_start_byte(int'(sel_sop_pos), DATA_WIDTH, SOP_POS_WIDTH) > int'(sel_eop_pos));
  assign release_pkt = sel_eop && !cont;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      lock_port  <= '0;
      rr_ptr     <= '0;
      out_vld    <= 1'b0;
      TX_DATA    <= '0;
      TX_SOP_POS <= '0;
      TX_EOP_POS <= '0;
      TX_SOP     <= 1'b0;
      TX_EOP     <= 1'b0;
    end else if (accept) begin
      out_vld    <= 1'b1;
      TX_DATA    <= sel_data;
      TX_SOP_POS <= sel_sop_pos;
      TX_EOP_POS <= sel_eop_pos;
      TX_SOP     <= sel_sop;
      TX_EOP     <= sel_eop;
      lock_port  <= sel_port;
      state      <= release_pkt ? IDLE : LOCKED;
      if (state == IDLE) rr_ptr <= next_ptr;
    end else if (TX_DST_RDY) begin
      out_vld <= 1'b0;
    end
  end

  assign TX_SRC_RDY = out_vld;

endmodule
